dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, memory and status signals around the data-memory arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          prio_mode;
    logic          p0_req;
    logic          p1_req;
    logic          p0_we;
    logic          p1_we;
    logic [AW-1:0] p0_addr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p1_wdata;
    logic          p0_gnt;
    logic          p1_gnt;
    logic          p0_rvalid;
    logic          p1_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [15:0]   p0_gcnt;
    logic [15:0]   p1_gcnt;

    modport master (
        output prio_mode, p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, mem_read,
               mem_write, mem_addr, mem_wdata, busy, p0_gcnt, p1_gcnt
    );

    modport slave (
        input  prio_mode, p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, mem_read,
               mem_write, mem_addr, mem_wdata, busy, p0_gcnt, p1_gcnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: each access takes one ACCESS cycle after an IDLE sample,
// read data is registered and returned one cycle later with a per-port rvalid pulse.
//
// state  | meaning
// IDLE   | sample requests; latch winner and its command when any req is high
// ACCESS | drive memory strobes and the winner's gnt for exactly one cycle
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          start;
    logic          win_d;
    // last_q doubles as the winner of the access in flight: 0 = port 0, 1 = port 1
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [15:0]   gcnt0_q;
    logic [15:0]   gcnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.p0_req || bus.p1_req) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == ACCESS);
        bus.p0_gnt    = (state_q == ACCESS) && !last_q;
        bus.p1_gnt    = (state_q == ACCESS) && last_q;
        bus.mem_read  = (state_q == ACCESS) && !we_q;
        bus.mem_write = (state_q == ACCESS) && we_q;
    end

    assign start = (state_q == IDLE) && (bus.p0_req || bus.p1_req);

    // Under contention in round-robin mode the port that was not granted last wins.
    always_comb begin
        win_d = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            win_d = bus.prio_mode ? 1'b0 : ~last_q;
        end else if (bus.p1_req) begin
            win_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            gcnt0_q   <= '0;
            gcnt1_q   <= '0;
        end else begin
            rvalid0_q <= (state_q == ACCESS) && !we_q && !last_q;
            rvalid1_q <= (state_q == ACCESS) && !we_q && last_q;
            if ((state_q == ACCESS) && !we_q) begin
                rdata_q <= bus.mem_rdata;
            end
            if (start) begin
                last_q  <= win_d;
                we_q    <= win_d ? bus.p1_we    : bus.p0_we;
                addr_q  <= win_d ? bus.p1_addr  : bus.p0_addr;
                wdata_q <= win_d ? bus.p1_wdata : bus.p0_wdata;
                if (!win_d && (gcnt0_q != 16'hFFFF)) begin
                    gcnt0_q <= gcnt0_q + 16'd1;
                end
                if (win_d && (gcnt1_q != 16'hFFFF)) begin
                    gcnt1_q <= gcnt1_q + 16'd1;
                end
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.p0_rvalid = rvalid0_q;
    assign bus.p1_rvalid = rvalid1_q;
    assign bus.p0_gcnt   = gcnt0_q;
    assign bus.p1_gcnt   = gcnt1_q;
endmodule
